// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit owning the HI/LO registers of the MIPS datapath.
// One shift-add or restoring shift-subtract step per clock on operand magnitudes, sign fixed at the end.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic               op_r;
  logic               neg_res;
  logic               neg_rem;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rmd;

  // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mag_a_in  = a_in[WIDTH-1] ? -a_in : a_in;
    mag_b_in  = b_in[WIDTH-1] ? -b_in : b_in;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, mag_b};
    if (op_r) begin
      if (rem_diff[WIDTH])
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
    prod = neg_res ? -acc : acc;
    quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM; hi/lo are only written in FIX so divide-by-zero leaves them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_r     <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      mag_b    <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            op_r    <= op;
            neg_res <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_rem <= a_in[WIDTH-1];
            mag_b   <= mag_b_in;
            acc     <= {{WIDTH{1'b0}}, mag_a_in};
            cnt     <= '0;
            if (op && (b_in == '0)) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1))
            state <= FIX;
        end
        FIX: begin
          if (op_r) begin
            hi <= rmd;
            lo <= quot;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a longint arithmetic model of HI/LO.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic; SV division truncates toward zero.
  task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b != 32'h0) begin
      q = sa / sb;
      r = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end
  endtask

  task automatic applyStimulus(input string tag, input logic o, input logic [31:0] a,
                               input logic [31:0] b, input bit poke);
    int cyc;
    int lat;
    int extra;
    bit busy_bad;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    model(o, a, b);
    lat = (o && b == 32'h0) ? 1 : 34;
    @(negedge clk);
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    cyc = 1; busy_bad = 0;
    while (!done && cyc < 60) begin
      if (cyc >= 2 && !busy) busy_bad = 1;
      if (poke && cyc == 5) begin
        start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, lat);
    checkOutput({tag, " busy held"}, {31'b0, busy_bad}, 32'h0);
    checkOutput({tag, " busy at done"}, {31'b0, busy}, 32'h0);
    checkOutput({tag, " div_zero"}, {31'b0, div_zero}, {31'b0, (o && b == 32'h0)});
    checkOutput({tag, " hi"}, hi, exp_hi);
    checkOutput({tag, " lo"}, lo, exp_lo);
    if (poke) begin
      start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd5;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " done pulse width"}, {31'b0, done}, 32'h0);
    if (poke) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      checkOutput({tag, " ignored starts"}, extra, 0);
      checkOutput({tag, " hi after ignore"}, hi, exp_hi);
      checkOutput({tag, " lo after ignore"}, lo, exp_lo);
    end
  endtask

  initial begin
    int pulses;
    logic        ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = 32'h0; b_in = 32'h0;
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    checkOutput("reset done", {31'b0, done}, 32'h0);
    checkOutput("reset div_zero", {31'b0, div_zero}, 32'h0);
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    applyStimulus("mult 7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, 0);
    checkOutput("mult 7x-3 hi const", hi, 32'hFFFFFFFF);
    checkOutput("mult 7x-3 lo const", lo, 32'hFFFFFFEB);
    applyStimulus("mult minxmin", 1'b0, 32'h80000000, 32'h80000000, 0);
    checkOutput("mult minxmin hi const", hi, 32'h40000000);
    applyStimulus("mult -1x-1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    applyStimulus("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 0);
    checkOutput("div -7/2 lo const", lo, 32'hFFFFFFFD);
    checkOutput("div -7/2 hi const", hi, 32'hFFFFFFFF);
    applyStimulus("div 100/7", 1'b1, 32'd100, 32'd7, 0);
    applyStimulus("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    checkOutput("div min/-1 lo const", lo, 32'h80000000);
    applyStimulus("div preload", 1'b1, 32'h451, 32'h20, 0);
    applyStimulus("div 5/0", 1'b1, 32'd5, 32'd0, 0);
    checkOutput("div 5/0 hi kept", hi, 32'h11);
    checkOutput("div 5/0 lo kept", lo, 32'h22);
    applyStimulus("mult 3x4 poke", 1'b0, 32'd3, 32'd4, 1);
    checkOutput("mult 3x4 lo const", lo, 32'd12);

    // Abort a divide with an asynchronous reset in the middle of a cycle.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_hi = 32'h0; exp_lo = 32'h0;
    checkOutput("abort busy", {31'b0, busy}, 32'h0);
    checkOutput("abort done", {31'b0, done}, 32'h0);
    checkOutput("abort div_zero", {31'b0, div_zero}, 32'h0);
    checkOutput("abort hi", hi, 32'h0);
    checkOutput("abort lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort no done", pulses, 0);
    applyStimulus("mult 2x3 after abort", 1'b0, 32'd2, 32'd3, 0);
    checkOutput("mult 2x3 lo const", lo, 32'd6);

    for (int i = 0; i < 20; i++) begin
      ro = $urandom_range(0, 1);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 9);
        2: rb = -$urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) ra = 32'h80000000;
      applyStimulus($sformatf("random %0d", i), ro, ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
